// File: rtl/seg_dynamic.sv
// Six-digit seven-segment scanner: double-dabble binary-to-BCD converter plus
// a time-multiplexed digit scan with decimal points and leading-zero blanking.
module seg_dynamic #(
  parameter int CNT_MAX = 49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic [1:0]  dbg_state
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_load;
  logic        w_shift;
  logic        w_update;
  logic [19:0] r_bin;
  logic [23:0] r_bcd;
  logic [23:0] r_bcd_disp;
  logic [4:0]  r_shift_cnt;
  logic [23:0] w_bcd_adj;
  logic [19:0] w_data_sat;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_idx;
  logic [5:0]  w_sig;
  logic        w_any;
  logic [3:0]  w_digit;
  logic [7:0]  w_dec;
  logic [7:0]  w_pat;

  assign dbg_state  = r_state;
  assign w_data_sat = (data > 20'd999_999) ? 20'd999_999 : data;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= S_LOAD;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:   w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_shift_cnt == 5'd19) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_LOAD;
      default:  w_state_nxt = S_LOAD;
    endcase
  end

  always_comb begin
    w_load   = (r_state == S_LOAD);
    w_shift  = (r_state == S_SHIFT);
    w_update = (r_state == S_UPDATE);
  end

  // Add-3 correction on every nibble of 5 or more before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_bcd_disp  <= '0;
      r_shift_cnt <= '0;
    end else begin
      if (w_load) begin
        r_bin       <= w_data_sat;
        r_bcd       <= '0;
        r_shift_cnt <= '0;
      end
      if (w_shift) begin
        {r_bcd, r_bin} <= {w_bcd_adj[22:0], r_bin, 1'b0};
        r_shift_cnt    <= r_shift_cnt + 5'd1;
      end
      if (w_update) r_bcd_disp <= r_bcd;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CW'(CNT_MAX)) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A digit is shown if it or any more significant digit/point is non-blank.
  always_comb begin
    w_any = 1'b0;
    w_sig = '0;
    for (int i = 5; i >= 0; i--) begin
      w_any    = w_any | (|r_bcd_disp[4*i +: 4]) | point[i];
      w_sig[i] = w_any;
    end
    w_sig[0] = 1'b1;
  end

  always_comb begin
    w_digit = r_bcd_disp[{r_idx, 2'b00} +: 4];
    case (w_digit)
      4'd0:    w_dec = 8'hC0;
      4'd1:    w_dec = 8'hF9;
      4'd2:    w_dec = 8'hA4;
      4'd3:    w_dec = 8'hB0;
      4'd4:    w_dec = 8'h99;
      4'd5:    w_dec = 8'h92;
      4'd6:    w_dec = 8'h82;
      4'd7:    w_dec = 8'hF8;
      4'd8:    w_dec = 8'h80;
      4'd9:    w_dec = 8'h90;
      default: w_dec = 8'hFF;
    endcase
    w_pat = 8'hFF;
    if (w_sig[r_idx]) w_pat = {w_dec[7] & ~point[r_idx], w_dec[6:0]};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || !seg_en) begin
      sel <= 6'b000000;
      seg <= 8'hFF;
    end else begin
      sel <= 6'b000001 << r_idx;
      seg <= w_pat;
    end
  end

endmodule

// File: tb/tb_seg_dynamic.sv
// Bench for seg_dynamic: per-cycle comparison against an arithmetic model of
// the display plus fixed-pattern checks for the documented scenarios.
module tb_seg_dynamic;

  localparam int CNT = 3;
  localparam int DW  = CNT + 1;
  localparam logic [7:0] LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [19:0] data;
  logic [5:0]  point;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Inputs seen at every rising edge since reset release (edge index 0 = E0).
  int          n_edge = 0;
  int          hist [4096];
  logic        en_h [4096];
  logic [5:0]  pt_h [4096];

  seg_dynamic #(.CNT_MAX(CNT)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .point     (point),
    .seg_en    (seg_en),
    .sel       (sel),
    .seg       (seg),
    .dbg_state (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      n_edge <= 0;
    end else if (n_edge < 4096) begin
      hist[n_edge] <= int'(data);
      en_h[n_edge] <= seg_en;
      pt_h[n_edge] <= point;
      n_edge       <= n_edge + 1;
    end
  end

  // Expected {sel, seg} right after edge m: digit (m / dwell) mod 6 of the
  // value latched at the start of the newest conversion that has completed.
  function automatic logic [13:0] exp_out(input int m);
    int         v;
    int         idx;
    int         p10;
    int         dig;
    logic [7:0] pat;
    logic [5:0] one_hot;
    if (!en_h[m]) return {6'b000000, 8'hFF};
    idx = (m / DW) % 6;
    v = 0;
    if (m >= 22) v = hist[22 * ((m - 22) / 22)];
    if (v > 999_999) v = 999_999;
    p10 = 1;
    for (int i = 0; i < idx; i++) p10 = p10 * 10;
    dig = (v / p10) % 10;
    if (idx == 0 || v >= p10 || (pt_h[m] >> idx) != 6'd0) begin
      pat = LUT[dig];
      if (pt_h[m][idx]) pat[7] = 1'b0;
    end else begin
      pat = 8'hFF;
    end
    one_hot = 6'b000001 << idx;
    return {one_hot, pat};
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (cycles) @(negedge sys_clk);
  endtask

  task automatic release_with(input logic [19:0] d, input logic [5:0] p, input logic en);
    data      = d;
    point     = p;
    seg_en    = en;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (sel !== 6'b000000 || seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset c=%0d: got sel=%b seg=%h, want sel=000000 seg=ff", c, sel, seg);
      end
    end
  endtask

  task automatic test_zero_display();
    logic [13:0] e;
    release_with(20'd0, 6'd0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      e = exp_out(n_edge - 1);
      n_cmp++;
      if ({sel, seg} !== e || (sel == 6'b000001 && seg !== 8'hC0)) begin
        n_fail++;
        $display("FAIL zero_display m=%0d: got %b/%h want %b/%h", n_edge - 1, sel, seg, e[13:8], e[7:0]);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [7:0]  want [6] = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [13:0] e;
    logic [5:0]  s;
    int          m;
    do_reset(2);
    release_with(20'd123456, 6'd0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      m = n_edge - 1;
      e = exp_out(m);
      n_cmp++;
      if ({sel, seg} !== e) begin
        n_fail++;
        $display("FAIL scan_model m=%0d: got %b/%h want %b/%h", m, sel, seg, e[13:8], e[7:0]);
      end
      if (m >= 24 && m < 52) begin
        s = 6'b000001 << ((m / DW) % 6);
        n_cmp++;
        if (sel !== s || seg !== want[(m / DW) % 6]) begin
          n_fail++;
          $display("FAIL scan_table m=%0d: got %b/%h want %b/%h", m, sel, seg, s, want[(m / DW) % 6]);
        end
      end
    end
  endtask

  task automatic test_point_blank();
    logic [7:0] want [6] = '{8'h92, 8'hC0, 8'h40, 8'hFF, 8'hFF, 8'hFF};
    int         m;
    do_reset(2);
    release_with(20'd5, 6'b000100, 1'b1);
    for (int c = 0; c < 50; c++) begin
      @(negedge sys_clk);
      m = n_edge - 1;
      if (m >= 24) begin
        n_cmp++;
        if (seg !== want[(m / DW) % 6] || {sel, seg} !== exp_out(m)) begin
          n_fail++;
          $display("FAIL point_blank m=%0d: got seg=%h want %h", m, seg, want[(m / DW) % 6]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [19:0] vals [3] = '{20'd1_000_000, 20'd1_048_575, 20'd999_999};
    int          m;
    for (int v = 0; v < 3; v++) begin
      do_reset(2);
      release_with(vals[v], 6'd0, 1'b1);
      for (int c = 0; c < 48; c++) begin
        @(negedge sys_clk);
        m = n_edge - 1;
        if (m >= 24) begin
          n_cmp++;
          if (seg !== 8'h90 || {sel, seg} !== exp_out(m)) begin
            n_fail++;
            $display("FAIL saturation data=%0d m=%0d: got seg=%h want 90", vals[v], m, seg);
          end
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    logic [13:0] e;
    int          m;
    do_reset(2);
    release_with(20'd123456, 6'd0, 1'b1);
    for (int c = 0; c < 48; c++) begin
      @(negedge sys_clk);
      m = n_edge - 1;
      e = exp_out(m);
      n_cmp++;
      if ({sel, seg} !== e) begin
        n_fail++;
        $display("FAIL enable_model m=%0d: got %b/%h want %b/%h", m, sel, seg, e[13:8], e[7:0]);
      end
      if (m == 37 || m == 38) begin
        n_cmp++;
        if (sel !== 6'b000000 || seg !== 8'hFF) begin
          n_fail++;
          $display("FAIL enable_off m=%0d: got %b/%h want 000000/ff", m, sel, seg);
        end
      end
      if (m == 39) begin
        n_cmp++;
        if (sel !== 6'b001000 || seg !== 8'hB0) begin
          n_fail++;
          $display("FAIL enable_on m=%0d: got %b/%h want 001000/b0", m, sel, seg);
        end
      end
      if (m == 40) begin
        n_cmp++;
        if (sel !== 6'b010000) begin
          n_fail++;
          $display("FAIL enable_phase m=%0d: got sel=%b want 010000", m, sel);
        end
      end
      if (m == 36) seg_en = 1'b0;
      if (m == 38) seg_en = 1'b1;
    end
  endtask

  task automatic test_mid_conversion();
    logic [13:0] e;
    int          m;
    do_reset(2);
    release_with(20'd42, 6'd0, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge sys_clk);
      m = n_edge - 1;
      e = exp_out(m);
      n_cmp++;
      if ({sel, seg} !== e) begin
        n_fail++;
        $display("FAIL midconv_model m=%0d: got %b/%h want %b/%h", m, sel, seg, e[13:8], e[7:0]);
      end
      if (m == 24 || m == 48) begin
        n_cmp++;
        if (sel !== 6'b000001 || seg !== ((m == 24) ? 8'hA4 : 8'hF8)) begin
          n_fail++;
          $display("FAIL midconv_value m=%0d: got %b/%h want 000001/%h", m, sel, seg,
                   (m == 24) ? 8'hA4 : 8'hF8);
        end
      end
      if (m == 5) data = 20'd77;
    end
  endtask

  task automatic test_mid_reset();
    logic [13:0] e;
    int          m;
    do_reset(2);
    release_with(20'd123456, 6'd0, 1'b1);
    while (n_edge < 72) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (sel !== 6'b000000 || seg !== 8'hFF) begin
        n_fail++;
        $display("FAIL midreset_hold c=%0d: got %b/%h want 000000/ff", c, sel, seg);
      end
    end
    sys_rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge sys_clk);
      m = n_edge - 1;
      e = exp_out(m);
      n_cmp++;
      if ({sel, seg} !== e || (m == 0 && {sel, seg} !== {6'b000001, 8'hC0})) begin
        n_fail++;
        $display("FAIL midreset_after m=%0d: got %b/%h want %b/%h", m, sel, seg, e[13:8], e[7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int r = 0; r < 4; r++) begin
      do_reset(2);
      release_with(20'($urandom_range(0, 1_048_575)), 6'($urandom_range(0, 63)), 1'b1);
      for (int c = 0; c < 300; c++) begin
        @(negedge sys_clk);
        e = exp_out(n_edge - 1);
        n_cmp++;
        if ({sel, seg} !== e) begin
          n_fail++;
          $display("FAIL random r=%0d m=%0d: got %b/%h want %b/%h", r, n_edge - 1, sel, seg,
                   e[13:8], e[7:0]);
        end
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 2))
            0:       data = 20'($urandom_range(0, 999));
            1:       data = 20'($urandom_range(0, 999_999));
            default: data = 20'($urandom_range(990_000, 1_048_575));
          endcase
        end
        if ($urandom_range(0, 31) == 0) point = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
        if ($urandom_range(0, 19) == 0) seg_en = ~seg_en;
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    data      = '0;
    point     = '0;
    seg_en    = 1'b1;
    test_reset();
    test_zero_display();
    test_scan_order();
    test_point_blank();
    test_saturation();
    test_enable_gating();
    test_mid_conversion();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
